// File: rtl/ascii_tolower_stream.sv
// Streaming ASCII lowercase converter with valid/ready handshake, output FIFO and per-message stats.
// Define TOLOWER_LATIN1_EN to also fold Latin-1 uppercase (0xC0-0xDE except 0xD7).
module ascii_tolower_stream #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             stat_valid,
    output logic [CNT_W-1:0] stat_bytes,
    output logic [CNT_W-1:0] stat_conv
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, IN_MSG} state_t;

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        logic hit;
        hit = (c >= 8'h41) && (c <= 8'h5A);
`ifdef TOLOWER_LATIN1_EN
        hit = hit || ((c >= 8'hC0) && (c <= 8'hDE) && (c != 8'hD7));
`endif
        return hit ? (c | 8'h20) : c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t          state_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     fill_reg, fill_next;
    logic            in_ready_reg;
    logic            stat_valid_reg;
    logic [CNT_W-1:0] cnt_bytes_reg, cnt_conv_reg;
    logic [CNT_W-1:0] stat_bytes_reg, stat_conv_reg;

    logic [7:0]      mem_data [FIFO_DEPTH];
    logic            mem_last [FIFO_DEPTH];

    logic            accept, pop, fifo_nonempty, conv_hit;
    logic [7:0]      conv_data;
    logic [CNT_W-1:0] bytes_total, conv_total;

    assign fifo_nonempty = (fill_reg != '0);
    assign accept        = in_valid && in_ready_reg;
    assign pop           = fifo_nonempty && out_ready;
    assign conv_data     = to_lower(in_data);
    assign conv_hit      = (conv_data != in_data);
    assign bytes_total   = sat_inc(cnt_bytes_reg);
    assign conv_total    = conv_hit ? sat_inc(cnt_conv_reg) : cnt_conv_reg;

    always_comb begin
        fill_next = fill_reg;
        case ({accept, pop})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase
    end

    // Storage needs no reset: fill gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr_reg] <= conv_data;
            mem_last[wr_ptr_reg] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fill_reg       <= '0;
            in_ready_reg   <= 1'b0;
            stat_valid_reg <= 1'b0;
            cnt_bytes_reg  <= '0;
            cnt_conv_reg   <= '0;
            stat_bytes_reg <= '0;
            stat_conv_reg  <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_reg + AW'(accept);
            rd_ptr_reg     <= rd_ptr_reg + AW'(pop);
            fill_reg       <= fill_next;
            // Registered so a same-cycle pop never opens the input while full.
            in_ready_reg   <= (fill_next != DEPTH_L);
            stat_valid_reg <= 1'b0;
            if (accept) begin
                if (in_last) begin
                    stat_bytes_reg <= bytes_total;
                    stat_conv_reg  <= conv_total;
                    cnt_bytes_reg  <= '0;
                    cnt_conv_reg   <= '0;
                    stat_valid_reg <= 1'b1;
                    state_reg      <= IDLE;
                end else begin
                    cnt_bytes_reg  <= bytes_total;
                    cnt_conv_reg   <= conv_total;
                    state_reg      <= IN_MSG;
                end
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = fifo_nonempty;
    assign out_data   = fifo_nonempty ? mem_data[rd_ptr_reg] : 8'h00;
    assign out_last   = fifo_nonempty ? mem_last[rd_ptr_reg] : 1'b0;
    assign busy       = (state_reg == IN_MSG);
    assign stat_valid = stat_valid_reg;
    assign stat_bytes = stat_bytes_reg;
    assign stat_conv  = stat_conv_reg;

endmodule
